// File: rtl/uart_fifo_bridge_if.sv
// CPU-side FIFO port plus the UART data-register handshake for uart_fifo_bridge.
// The slave view belongs to the bridge; the master view to whoever drives it.
interface uart_fifo_bridge_if #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
);
  logic              tx_wr;
  logic [7:0]        tx_data;
  logic              tx_full;
  logic [TX_AW:0]    tx_level;
  logic              rx_rd;
  logic [7:0]        rx_data;
  logic              rx_empty;
  logic [RX_AW:0]    rx_level;
  logic              rx_overrun;
  logic              ovr_clr;
  logic              uart_data_we;
  logic [31:0]       uart_data_di;
  logic              uart_data_wait;
  logic              uart_data_re;
  logic [31:0]       uart_data_do;

  modport slave (
    input  tx_wr, tx_data, rx_rd, ovr_clr, uart_data_wait, uart_data_do,
    output tx_full, tx_level, rx_data, rx_empty, rx_level, rx_overrun,
           uart_data_we, uart_data_di, uart_data_re
  );

  modport master (
    output tx_wr, tx_data, rx_rd, ovr_clr, uart_data_wait, uart_data_do,
    input  tx_full, tx_level, rx_data, rx_empty, rx_level, rx_overrun,
           uart_data_we, uart_data_di, uart_data_re
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Byte FIFOs between the CPU and the UART data register: TX drains into the
// UART write port under its stall, RX polls the read port and flags overrun.
module uart_fifo_bridge_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);
  localparam logic [AW:0] ONE = 1;

  logic [7:0]  mem [2**AW];
  logic [AW:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head reads as 0 while empty so nothing undefined leaks out after reset.
  assign rdata = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
endmodule

module uart_fifo_bridge #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic                clk,
  input  logic                resetn,
  uart_fifo_bridge_if.slave   bus
);
  logic [7:0]     tx_head, rx_head;
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic [TX_AW:0] tx_level;
  logic [RX_AW:0] rx_level;
  logic           tx_push, tx_pop, rx_push, rx_pop, rx_valid, ovr_set;
  logic           overrun;

  // TX: full is sampled before the edge, so a pop cannot make room for a push.
  assign tx_push = bus.tx_wr && !tx_full;
  assign tx_pop  = !tx_empty && !bus.uart_data_wait;

  uart_fifo_bridge_fifo #(.AW(TX_AW)) u_tx (
    .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop),
    .wdata(bus.tx_data), .rdata(tx_head), .empty(tx_empty), .full(tx_full),
    .level(tx_level)
  );

  // RX: a same-cycle pop frees the slot, so the byte is kept rather than dropped.
  assign rx_valid = (bus.uart_data_do[31:8] == 24'h0);
  assign rx_pop   = bus.rx_rd && !rx_empty;
  assign rx_push  = rx_valid && (!rx_full || rx_pop);
  assign ovr_set  = rx_valid && rx_full && !rx_pop;

  uart_fifo_bridge_fifo #(.AW(RX_AW)) u_rx (
    .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop),
    .wdata(bus.uart_data_do[7:0]), .rdata(rx_head), .empty(rx_empty), .full(rx_full),
    .level(rx_level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          overrun <= 1'b0;
    else if (ovr_set)     overrun <= 1'b1;
    else if (bus.ovr_clr) overrun <= 1'b0;
  end

  assign bus.tx_full      = tx_full;
  assign bus.tx_level     = tx_level;
  assign bus.rx_data      = rx_head;
  assign bus.rx_empty     = rx_empty;
  assign bus.rx_level     = rx_level;
  assign bus.rx_overrun   = overrun;
  assign bus.uart_data_we = !tx_empty;
  assign bus.uart_data_di = {24'h0, tx_head};
  // Read strobe is asserted even when the byte is dropped, so the UART always drains.
  assign bus.uart_data_re = rx_valid;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: expected TX/RX bytes are queued as
// stimulus is driven and popped when the DUT accepts or presents them.
module tb_uart_fifo_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_bridge_if #(.TX_AW(4), .RX_AW(4)) bus ();
  uart_fifo_bridge #(.TX_AW(4), .RX_AW(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.tx_wr = 0; bus.tx_data = 0; bus.rx_rd = 0; bus.ovr_clr = 0;
    bus.uart_data_wait = 0; bus.uart_data_do = 32'hFFFF_FFFF;
  endtask

  // UART-side model: every accept pops the TX scoreboard; di must hold while stalled.
  initial begin
    logic        hold_vld;
    logic [31:0] hold_di;
    logic [7:0]  exp;
    hold_vld = 0; hold_di = 0;
    forever begin
      @(negedge clk);
      if (!resetn || !bus.uart_data_we) hold_vld = 0;
      else begin
        if (hold_vld) begin
          n_cmp++;
          if (bus.uart_data_di !== hold_di) begin
            $display("FAIL di_stable: got %08h want %08h", bus.uart_data_di, hold_di); n_err++;
          end
        end
        if (bus.uart_data_wait) begin
          hold_vld = 1; hold_di = bus.uart_data_di;
        end else begin
          hold_vld = 0;
          exp = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
          n_cmp++;
          if (bus.uart_data_di !== {24'h0, exp}) begin
            $display("FAIL tx_accept: got %08h want %08h", bus.uart_data_di, {24'h0, exp}); n_err++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    idle(); resetn = 0; #12;
    n_cmp++;
    if ({bus.tx_full, bus.tx_level, bus.rx_empty, bus.rx_level, bus.uart_data_we, bus.uart_data_re,
         bus.rx_overrun} !== {1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_flags: got full=%b lvl=%0d empty=%b rlvl=%0d we=%b re=%b ovr=%b",
               bus.tx_full, bus.tx_level, bus.rx_empty, bus.rx_level, bus.uart_data_we,
               bus.uart_data_re, bus.rx_overrun);
      n_err++;
    end
    n_cmp++;
    if ({bus.uart_data_di, bus.rx_data} !== 40'h0) begin
      $display("FAIL reset_data: got di=%08h rx_data=%02h want 0", bus.uart_data_di, bus.rx_data); n_err++;
    end
    step(); resetn = 1; step();
  endtask

  task automatic test_tx_basic();
    bus.tx_wr = 1; bus.tx_data = 8'h55; tx_q.push_back(8'h55);
    n_cmp++;
    if (bus.uart_data_we !== 1'b0) begin
      $display("FAIL tx_we_early: got %b want 0", bus.uart_data_we); n_err++;
    end
    step();
    bus.tx_data = 8'hA3; tx_q.push_back(8'hA3);
    n_cmp++;
    if ({bus.uart_data_we, bus.uart_data_di} !== {1'b1, 32'h55}) begin
      $display("FAIL tx_latency: got we=%b di=%08h want we=1 di=00000055", bus.uart_data_we, bus.uart_data_di); n_err++;
    end
    step(); bus.tx_wr = 0;
    step(); step();
    n_cmp++;
    if ({bus.tx_level, bus.uart_data_we, tx_q.size() == 0} !== {5'd0, 1'b0, 1'b1}) begin
      $display("FAIL tx_basic_drain: got lvl=%0d we=%b q=%0d want 0/0/0", bus.tx_level, bus.uart_data_we, tx_q.size()); n_err++;
    end
  endtask

  task automatic test_tx_full();
    int cyc;
    bus.uart_data_wait = 1;
    for (int i = 0; i < 16; i++) begin
      bus.tx_wr = 1; bus.tx_data = 8'(8'h10 + i); tx_q.push_back(8'(8'h10 + i)); step();
    end
    bus.tx_wr = 0;
    n_cmp++;
    if ({bus.tx_full, bus.tx_level} !== {1'b1, 5'd16}) begin
      $display("FAIL tx_full: got full=%b lvl=%0d want 1/16", bus.tx_full, bus.tx_level); n_err++;
    end
    bus.tx_wr = 1; bus.tx_data = 8'hEE; step(); bus.tx_wr = 0; step();
    n_cmp++;
    if ({bus.tx_full, bus.tx_level} !== {1'b1, 5'd16}) begin
      $display("FAIL tx_push_full: got full=%b lvl=%0d want 1/16", bus.tx_full, bus.tx_level); n_err++;
    end
    cyc = 0;
    while (bus.tx_level != 0 && cyc < 200) begin
      bus.uart_data_wait = 1'($urandom_range(0, 1)); step(); cyc++;
    end
    bus.uart_data_wait = 0; step();
    n_cmp++;
    if (cyc >= 200 || tx_q.size() != 0 || bus.uart_data_we !== 1'b0) begin
      $display("FAIL tx_full_drain: got cycles=%0d left=%0d we=%b want <200/0/0", cyc, tx_q.size(), bus.uart_data_we); n_err++;
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] exp;
    bus.uart_data_do = 32'h0000_003C; rx_q.push_back(8'h3C);
    n_cmp++;
    if (bus.uart_data_re !== 1'b1) begin
      $display("FAIL rx_re: got %b want 1", bus.uart_data_re); n_err++;
    end
    step(); bus.uart_data_do = 32'hFFFF_FFFF;
    n_cmp++;
    if ({bus.uart_data_re, bus.rx_empty, bus.rx_level, bus.rx_data} !== {1'b0, 1'b0, 5'd1, 8'h3C}) begin
      $display("FAIL rx_capture: got re=%b empty=%b lvl=%0d data=%02h want 0/0/1/3c",
               bus.uart_data_re, bus.rx_empty, bus.rx_level, bus.rx_data); n_err++;
    end
    bus.rx_rd = 1;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
    n_cmp++;
    if (bus.rx_data !== exp) begin
      $display("FAIL rx_order: got %02h want %02h", bus.rx_data, exp); n_err++;
    end
    step();
    n_cmp++;
    if (bus.rx_empty !== 1'b1) begin
      $display("FAIL rx_pop_empty: got %b want 1", bus.rx_empty); n_err++;
    end
    step(); bus.rx_rd = 0;
    bus.uart_data_do = 32'h0000_0100;
    n_cmp++;
    if ({bus.uart_data_re, bus.rx_level} !== {1'b0, 5'd0}) begin
      $display("FAIL rx_invalid: got re=%b lvl=%0d want 0/0", bus.uart_data_re, bus.rx_level); n_err++;
    end
    step(); bus.uart_data_do = 32'hFFFF_FFFF;
    n_cmp++;
    if ({bus.rx_empty, bus.rx_level} !== {1'b1, 5'd0}) begin
      $display("FAIL rx_no_capture: got empty=%b lvl=%0d want 1/0", bus.rx_empty, bus.rx_level); n_err++;
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      bus.uart_data_do = {24'h0, 8'(8'h80 + i)}; rx_q.push_back(8'(8'h80 + i)); step();
    end
    bus.uart_data_do = 32'h0000_0099;
    n_cmp++;
    if ({bus.rx_level, bus.uart_data_re} !== {5'd16, 1'b1}) begin
      $display("FAIL rx_fill: got lvl=%0d re=%b want 16/1", bus.rx_level, bus.uart_data_re); n_err++;
    end
    step(); bus.uart_data_do = 32'hFFFF_FFFF;
    n_cmp++;
    if ({bus.rx_overrun, bus.rx_level} !== {1'b1, 5'd16}) begin
      $display("FAIL rx_drop: got ovr=%b lvl=%0d want 1/16", bus.rx_overrun, bus.rx_level); n_err++;
    end
    bus.uart_data_do = 32'h0000_0099; bus.rx_rd = 1;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
    rx_q.push_back(8'h99);
    n_cmp++;
    if (bus.rx_data !== exp) begin
      $display("FAIL rx_order: got %02h want %02h", bus.rx_data, exp); n_err++;
    end
    step(); bus.uart_data_do = 32'hFFFF_FFFF; bus.rx_rd = 0;
    n_cmp++;
    if ({bus.rx_overrun, bus.rx_level} !== {1'b1, 5'd16}) begin
      $display("FAIL rx_full_pop: got ovr=%b lvl=%0d want 1/16", bus.rx_overrun, bus.rx_level); n_err++;
    end
    bus.ovr_clr = 1; step(); bus.ovr_clr = 0;
    n_cmp++;
    if (bus.rx_overrun !== 1'b0) begin
      $display("FAIL ovr_clr: got %b want 0", bus.rx_overrun); n_err++;
    end
    bus.uart_data_do = 32'h0000_0077; bus.ovr_clr = 1; step();
    bus.uart_data_do = 32'hFFFF_FFFF; bus.ovr_clr = 0;
    n_cmp++;
    if (bus.rx_overrun !== 1'b1) begin
      $display("FAIL ovr_set_wins: got %b want 1", bus.rx_overrun); n_err++;
    end
    bus.ovr_clr = 1; step(); bus.ovr_clr = 0;
    for (int i = 0; i < 16; i++) begin
      bus.rx_rd = 1;
      exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
      n_cmp++;
      if (bus.rx_data !== exp) begin
        $display("FAIL rx_order: got %02h want %02h", bus.rx_data, exp); n_err++;
      end
      step();
    end
    bus.rx_rd = 0;
    n_cmp++;
    if ({bus.rx_empty, bus.rx_overrun} !== {1'b1, 1'b0}) begin
      $display("FAIL rx_drain: got empty=%b ovr=%b want 1/0", bus.rx_empty, bus.rx_overrun); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    int cyc;
    bus.uart_data_wait = 1;
    for (int i = 0; i < 8; i++) begin
      bus.tx_wr = 1; bus.tx_data = 8'(8'hA0 + i); tx_q.push_back(8'(8'hA0 + i));
      bus.uart_data_do = {24'h0, 8'(8'hC0 + i)}; rx_q.push_back(8'(8'hC0 + i));
      step();
    end
    bus.tx_wr = 0; bus.uart_data_do = 32'hFFFF_FFFF;
    n_cmp++;
    if ({bus.tx_level, bus.rx_level} !== {5'd8, 5'd8}) begin
      $display("FAIL b2b_prefill: got tx=%0d rx=%0d want 8/8", bus.tx_level, bus.rx_level); n_err++;
    end
    for (int i = 0; i < 40; i++) begin
      bus.uart_data_wait = 0;
      bus.tx_wr = 1; bus.tx_data = 8'(i * 3 + 1); tx_q.push_back(8'(i * 3 + 1));
      bus.rx_rd = 1;
      exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
      n_cmp++;
      if (bus.rx_data !== exp) begin
        $display("FAIL rx_order: got %02h want %02h", bus.rx_data, exp); n_err++;
      end
      bus.uart_data_do = {24'h0, 8'(i * 5 + 7)}; rx_q.push_back(8'(i * 5 + 7));
      step();
      n_cmp++;
      if ({bus.tx_level, bus.rx_level} !== {5'd8, 5'd8}) begin
        $display("FAIL b2b_level: got tx=%0d rx=%0d want 8/8", bus.tx_level, bus.rx_level); n_err++;
      end
    end
    bus.tx_wr = 0; bus.rx_rd = 0; bus.uart_data_do = 32'hFFFF_FFFF;
    cyc = 0;
    while (bus.tx_level != 0 && cyc < 50) begin step(); cyc++; end
    for (int i = 0; i < 8; i++) begin
      bus.rx_rd = 1;
      exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
      n_cmp++;
      if (bus.rx_data !== exp) begin
        $display("FAIL rx_order: got %02h want %02h", bus.rx_data, exp); n_err++;
      end
      step();
    end
    bus.rx_rd = 0;
    n_cmp++;
    if (cyc >= 50 || tx_q.size() != 0 || bus.rx_empty !== 1'b1) begin
      $display("FAIL b2b_drain: got cycles=%0d txq=%0d rx_empty=%b want <50/0/1", cyc, tx_q.size(), bus.rx_empty); n_err++;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    int cyc;
    bus.uart_data_wait = 1;
    for (int i = 0; i < 5; i++) begin
      bus.tx_wr = 1; bus.tx_data = 8'(8'h30 + i); tx_q.push_back(8'(8'h30 + i)); step();
    end
    bus.tx_wr = 0;
    n_cmp++;
    if (bus.tx_level !== 5'd5) begin
      $display("FAIL ar_prefill: got %0d want 5", bus.tx_level); n_err++;
    end
    bus.uart_data_wait = 0;
    #2; resetn = 0; tx_q.delete(); rx_q.delete();
    #1;
    n_cmp++;
    if ({bus.tx_level, bus.uart_data_we} !== {5'd0, 1'b0}) begin
      $display("FAIL async_reset: got lvl=%0d we=%b want 0/0", bus.tx_level, bus.uart_data_we); n_err++;
    end
    step(); step(); resetn = 1; step();
    bus.tx_wr = 1; bus.tx_data = 8'h42; tx_q.push_back(8'h42);
    bus.uart_data_do = 32'h0000_005A; rx_q.push_back(8'h5A);
    step(); bus.tx_wr = 0; bus.uart_data_do = 32'hFFFF_FFFF;
    bus.rx_rd = 1;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
    n_cmp++;
    if (bus.rx_data !== exp) begin
      $display("FAIL rx_order: got %02h want %02h", bus.rx_data, exp); n_err++;
    end
    step(); bus.rx_rd = 0;
    cyc = 0;
    while (bus.tx_level != 0 && cyc < 20) begin step(); cyc++; end
    step();
    n_cmp++;
    if (cyc >= 20 || tx_q.size() != 0 || bus.rx_empty !== 1'b1) begin
      $display("FAIL ar_recover: got cycles=%0d txq=%0d rx_empty=%b want <20/0/1", cyc, tx_q.size(), bus.rx_empty); n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_basic();
    test_rx_overrun();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
